// File: rtl/az_seq_pkg.sv
// Shared encodings for the auto-zero sample sequencer.
// Holds the state enum, the default AZ mux codes and the reg_mode bit positions.
package az_seq_pkg;

  localparam logic [3:0] AZ_MUX_HI_DEF = 4'b0001;
  localparam logic [3:0] AZ_MUX_LO_DEF = 4'b0010;
  localparam int         SETTLE_W_DEF  = 24;

  localparam int REG_MODE_RUN_BIT   = 0;
  localparam int REG_MODE_AZ_EN_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETTLE_HI = 3'd1,
    ST_SAMPLE_HI = 3'd2,
    ST_SETTLE_LO = 3'd3,
    ST_SAMPLE_LO = 3'd4
  } state_t;

  // A zero settle request still costs one cycle, so the load value clamps at 0.
  function automatic logic [31:0] settle_load(input logic [31:0] n);
    return (n == 32'd0) ? 32'd0 : n - 32'd1;
  endfunction

endpackage

// File: rtl/az_seq_phase_counter.sv
// Loadable 32-bit down-counter shared by the settle and sample phases.
// Load wins over decrement; the count holds at zero until reloaded.
module az_seq_phase_counter (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  output logic [31:0] o_value,
  output logic        o_zero
);

  logic [31:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= 32'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != 32'd0) begin
      r_count <= r_count - 32'd1;
    end
  end

  assign o_value = r_count;
  assign o_zero  = (r_count == 32'd0);

endmodule

// File: rtl/az_sample_sequencer.sv
// DMM auto-zero sequencer: HI/LO mux phases, settle wait, then a fixed ADC aperture.
// Every output is registered; sample_done marks the first cycle after each aperture.
module az_sample_sequencer
  import az_seq_pkg::*;
#(
  parameter logic [3:0] AZ_MUX_HI = AZ_MUX_HI_DEF,
  parameter logic [3:0] AZ_MUX_LO = AZ_MUX_LO_DEF,
  parameter int         SETTLE_W  = SETTLE_W_DEF
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_run,
  input  logic                i_az_enable,
  input  logic [31:0]         i_sample_n,
  input  logic [SETTLE_W-1:0] i_settle_n,
  output logic [3:0]          o_az_mux,
  output logic                o_aperture,
  output logic                o_phase_lo,
  output logic                o_sample_done,
  output logic [31:0]         o_sample_count
);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_az_mux, w_az_mux_nxt;
  logic        r_aperture, w_aperture_nxt;
  logic        r_phase_lo, w_phase_lo_nxt;
  logic        r_sample_done, w_sample_done_nxt;
  logic [31:0] r_sample_count, w_sample_count_nxt;

  logic        w_cnt_load;
  logic [31:0] w_cnt_load_val;
  logic [31:0] w_cnt_value;
  logic        w_cnt_zero;
  logic [31:0] w_settle_ld;
  logic [31:0] w_sample_ld;
  logic        w_start_ok;

  assign w_settle_ld = settle_load(32'(i_settle_n));
  assign w_sample_ld = i_sample_n - 32'd1;
  assign w_start_ok  = i_run && (i_sample_n != 32'd0);

  az_seq_phase_counter u_phase_counter (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .o_value    (w_cnt_value),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_az_mux_nxt       = r_az_mux;
    w_aperture_nxt     = r_aperture;
    w_phase_lo_nxt     = r_phase_lo;
    w_sample_done_nxt  = 1'b0;
    w_sample_count_nxt = r_sample_count;
    w_cnt_load         = 1'b0;
    w_cnt_load_val     = w_settle_ld;

    case (r_state)
      ST_IDLE: begin
        w_az_mux_nxt   = AZ_MUX_LO;
        w_aperture_nxt = 1'b0;
        w_phase_lo_nxt = 1'b0;
        if (w_start_ok) begin
          w_state_nxt    = ST_SETTLE_HI;
          w_az_mux_nxt   = AZ_MUX_HI;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = w_settle_ld;
        end
      end

      ST_SETTLE_HI: begin
        w_phase_lo_nxt = 1'b0;
        if (!i_run) begin
          w_state_nxt    = ST_IDLE;
          w_az_mux_nxt   = AZ_MUX_LO;
          w_aperture_nxt = 1'b0;
        end else if (w_cnt_zero) begin
          w_state_nxt    = ST_SAMPLE_HI;
          w_aperture_nxt = 1'b1;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = w_sample_ld;
        end
      end

      ST_SAMPLE_HI: begin
        // A completing aperture is always credited, even if run drops on this edge.
        if (w_cnt_zero) begin
          w_sample_done_nxt  = 1'b1;
          w_phase_lo_nxt     = 1'b0;
          w_sample_count_nxt = r_sample_count + 32'd1;
          if (!i_run) begin
            w_state_nxt    = ST_IDLE;
            w_az_mux_nxt   = AZ_MUX_LO;
            w_aperture_nxt = 1'b0;
          end else if (i_az_enable) begin
            w_state_nxt    = ST_SETTLE_LO;
            w_az_mux_nxt   = AZ_MUX_LO;
            w_aperture_nxt = 1'b0;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = w_settle_ld;
          end else begin
            w_cnt_load     = 1'b1;
            w_cnt_load_val = w_sample_ld;
          end
        end else if (!i_run) begin
          w_state_nxt    = ST_IDLE;
          w_az_mux_nxt   = AZ_MUX_LO;
          w_aperture_nxt = 1'b0;
        end
      end

      ST_SETTLE_LO: begin
        w_phase_lo_nxt = 1'b1;
        if (!i_run) begin
          w_state_nxt    = ST_IDLE;
          w_az_mux_nxt   = AZ_MUX_LO;
          w_aperture_nxt = 1'b0;
          w_phase_lo_nxt = 1'b0;
        end else if (w_cnt_zero) begin
          w_state_nxt    = ST_SAMPLE_LO;
          w_aperture_nxt = 1'b1;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = w_sample_ld;
        end
      end

      ST_SAMPLE_LO: begin
        w_phase_lo_nxt = 1'b1;
        if (w_cnt_zero) begin
          w_sample_done_nxt = 1'b1;
          w_aperture_nxt    = 1'b0;
          if (w_start_ok) begin
            w_state_nxt    = ST_SETTLE_HI;
            w_az_mux_nxt   = AZ_MUX_HI;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = w_settle_ld;
          end else begin
            w_state_nxt  = ST_IDLE;
            w_az_mux_nxt = AZ_MUX_LO;
          end
        end else if (!i_run) begin
          w_state_nxt    = ST_IDLE;
          w_az_mux_nxt   = AZ_MUX_LO;
          w_aperture_nxt = 1'b0;
          w_phase_lo_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt    = ST_IDLE;
        w_az_mux_nxt   = AZ_MUX_LO;
        w_aperture_nxt = 1'b0;
        w_phase_lo_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_az_mux       <= AZ_MUX_LO;
      r_aperture     <= 1'b0;
      r_phase_lo     <= 1'b0;
      r_sample_done  <= 1'b0;
      r_sample_count <= 32'd0;
    end else begin
      r_az_mux       <= w_az_mux_nxt;
      r_aperture     <= w_aperture_nxt;
      r_phase_lo     <= w_phase_lo_nxt;
      r_sample_done  <= w_sample_done_nxt;
      r_sample_count <= w_sample_count_nxt;
    end
  end

  a_cnt_zero_consistent : assert property (
    @(posedge i_clk) disable iff (i_reset) w_cnt_zero == (w_cnt_value == 32'd0));

  assign o_az_mux       = r_az_mux;
  assign o_aperture     = r_aperture;
  assign o_phase_lo     = r_phase_lo;
  assign o_sample_done  = r_sample_done;
  assign o_sample_count = r_sample_count;

endmodule

// File: tb/tb_az_sample_sequencer.sv
// Directed bench for az_sample_sequencer: expected sample_done events are queued
// up front and a negedge monitor pops and compares them as the pulses appear.
module tb_az_sample_sequencer;

  localparam logic [3:0] MUX_HI = 4'b0001;
  localparam logic [3:0] MUX_LO = 4'b0010;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        az_en;
  logic [31:0] sample_n;
  logic [23:0] settle_n;
  logic [3:0]  az_mux;
  logic        aperture;
  logic        phase_lo;
  logic        sample_done;
  logic [31:0] sample_count;

  az_sample_sequencer dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_run          (run),
    .i_az_enable    (az_en),
    .i_sample_n     (sample_n),
    .i_settle_n     (settle_n),
    .o_az_mux       (az_mux),
    .o_aperture     (aperture),
    .o_phase_lo     (phase_lo),
    .o_sample_done  (sample_done),
    .o_sample_count (sample_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        pl;
    logic [31:0] cnt;
    logic [3:0]  mux;
    logic        ap;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
  endtask

  task automatic push(input int c, input logic pl, input logic [31:0] cnt,
                      input logic [3:0] mux, input logic ap);
    exp_t e;
    e.cyc = c; e.pl = pl; e.cnt = cnt; e.mux = mux; e.ap = ap;
    exp_q.push_back(e);
  endtask

  // Monitor: every sample_done pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (sample_done === 1'b1) begin
      exp_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_done: pulse at cycle %0d, want none", cyc);
      end else begin
        e = exp_q.pop_front();
        if (cyc == e.cyc && phase_lo === e.pl && sample_count === e.cnt &&
            az_mux === e.mux && aperture === e.ap)
          n_pass++;
        else
          $display("FAIL done_event: got cyc=%0d pl=%0b cnt=0x%0h mux=0x%0h ap=%0b, want cyc=%0d pl=%0b cnt=0x%0h mux=0x%0h ap=%0b",
                   cyc, phase_lo, sample_count, az_mux, aperture,
                   e.cyc, e.pl, e.cnt, e.mux, e.ap);
      end
    end
  end

  initial begin
    int c;
    reset = 1'b1; run = 1'b0; az_en = 1'b0; sample_n = 32'd0; settle_n = 24'd0;
    repeat (2) @(negedge clk);
    chk("rst_mux", 32'(az_mux), 32'(MUX_LO));
    chk("rst_ap", 32'(aperture), 32'd0);
    chk("rst_pl", 32'(phase_lo), 32'd0);
    chk("rst_done", 32'(sample_done), 32'd0);
    chk("rst_cnt", sample_count, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Alternating HI/LO, settle 3, sample 5: 16-cycle period.
    settle_n = 24'd3; sample_n = 32'd5; az_en = 1'b1; c = cyc; run = 1'b1;
    push(c + 9,  1'b0, 32'd1, MUX_LO, 1'b0);
    push(c + 17, 1'b1, 32'd1, MUX_HI, 1'b0);
    push(c + 25, 1'b0, 32'd2, MUX_LO, 1'b0);
    push(c + 33, 1'b1, 32'd2, MUX_HI, 1'b0);
    repeat (8) @(negedge clk);
    chk("t1_hi_mux", 32'(az_mux), 32'(MUX_HI));
    chk("t1_hi_ap", 32'(aperture), 32'd1);
    chk("t1_hi_pl", 32'(phase_lo), 32'd0);
    repeat (4) @(negedge clk);
    chk("t1_lo_mux", 32'(az_mux), 32'(MUX_LO));
    chk("t1_lo_ap", 32'(aperture), 32'd1);
    chk("t1_lo_pl", 32'(phase_lo), 32'd1);
    repeat (22) @(negedge clk);
    run = 1'b0;
    repeat (2) @(negedge clk);
    chk("t1_end_mux", 32'(az_mux), 32'(MUX_LO));
    chk("t1_end_ap", 32'(aperture), 32'd0);
    chk("t1_end_cnt", sample_count, 32'd2);
    chk("t1_pending", 32'(exp_q.size()), 32'd0);

    // HI only, settle 3, sample 4: aperture held high, done every 4 cycles.
    az_en = 1'b0; sample_n = 32'd4; c = cyc; run = 1'b1;
    push(c + 8,  1'b0, 32'd3, MUX_HI, 1'b1);
    push(c + 12, 1'b0, 32'd4, MUX_HI, 1'b1);
    push(c + 16, 1'b0, 32'd5, MUX_HI, 1'b1);
    repeat (14) @(negedge clk);
    chk("t2_ap_cont", 32'(aperture), 32'd1);
    repeat (4) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("t2_abort_mux", 32'(az_mux), 32'(MUX_LO));
    chk("t2_abort_ap", 32'(aperture), 32'd0);
    chk("t2_cnt", sample_count, 32'd5);

    // sample_n of zero keeps the sequencer parked in IDLE.
    sample_n = 32'd0; run = 1'b1;
    repeat (20) @(negedge clk);
    chk("t3_mux", 32'(az_mux), 32'(MUX_LO));
    chk("t3_ap", 32'(aperture), 32'd0);
    chk("t3_cnt", sample_count, 32'd5);
    run = 1'b0;
    @(negedge clk);

    // settle_n=0 still costs one settle cycle; sample_n=1.
    settle_n = 24'd0; sample_n = 32'd1; az_en = 1'b1; c = cyc; run = 1'b1;
    push(c + 3, 1'b0, 32'd6, MUX_LO, 1'b0);
    push(c + 5, 1'b1, 32'd6, MUX_HI, 1'b0);
    push(c + 7, 1'b0, 32'd7, MUX_LO, 1'b0);
    push(c + 9, 1'b1, 32'd7, MUX_HI, 1'b0);
    repeat (2) @(negedge clk);
    chk("t4_first_ap", 32'(aperture), 32'd1);
    repeat (7) @(negedge clk);
    run = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_cnt", sample_count, 32'd7);
    chk("t4_pending", 32'(exp_q.size()), 32'd0);

    // run dropped in the second cycle of SAMPLE_HI, then restarted.
    settle_n = 24'd3; sample_n = 32'd5; az_en = 1'b1; run = 1'b1;
    repeat (5) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("t5_abort_mux", 32'(az_mux), 32'(MUX_LO));
    chk("t5_abort_ap", 32'(aperture), 32'd0);
    repeat (5) @(negedge clk);
    chk("t5_abort_cnt", sample_count, 32'd7);
    c = cyc; run = 1'b1;
    push(c + 9, 1'b0, 32'd8, MUX_LO, 1'b0);
    @(negedge clk);
    chk("t5_restart_mux", 32'(az_mux), 32'(MUX_HI));
    chk("t5_restart_ap", 32'(aperture), 32'd0);
    repeat (9) @(negedge clk);
    run = 1'b0;
    repeat (2) @(negedge clk);

    // sample_count wrap from all-ones.
    az_en = 1'b0; c = cyc; run = 1'b1;
    push(c + 9,  1'b0, 32'd0, MUX_HI, 1'b1);
    push(c + 14, 1'b0, 32'd1, MUX_HI, 1'b1);
    repeat (2) @(negedge clk);
    force dut.r_sample_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_sample_count;
    repeat (13) @(negedge clk);
    run = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_cnt", sample_count, 32'd1);

    // Reset asserted in SAMPLE_LO.
    az_en = 1'b1; c = cyc; run = 1'b1;
    push(c + 9, 1'b0, 32'd2, MUX_LO, 1'b0);
    repeat (13) @(negedge clk);
    chk("t7_pre_ap", 32'(aperture), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("t7_rst_mux", 32'(az_mux), 32'(MUX_LO));
    chk("t7_rst_ap", 32'(aperture), 32'd0);
    chk("t7_rst_pl", 32'(phase_lo), 32'd0);
    chk("t7_rst_done", 32'(sample_done), 32'd0);
    chk("t7_rst_cnt", sample_count, 32'd0);
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("t7_idle_mux", 32'(az_mux), 32'(MUX_LO));
    chk("final_pending", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
